regwrite_sequencer: RTL

- Multicycle control block that owns the register-file write port.
- Accepts write-back commands from the main control FSM and issues them as single or back-to-back register writes.
- Drives the 2-bit write-register mux selector, the write-data source select and reg_write.
- Sequences the two-write POP instruction (rt, then $sp) and stalls on hold.

---
 rtl/regwrite_sequencer_if.sv | 29 ++
 rtl/regwrite_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/regwrite_sequencer_if.sv
// Register-file write-port command and control bundle between the main control FSM
// (master) and the write-back sequencer (slave).
interface regwrite_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [2:0]         cmd_src;
    logic               hold;
    logic               flush;
    logic [1:0]         wr_sel;
    logic [2:0]         wd_sel;
    logic               reg_write;
    logic               busy;
    logic               done;
    logic               err_op;
    logic [COUNT_W-1:0] write_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, hold, flush,
        output cmd_ready, wr_sel, wd_sel, reg_write, busy, done, err_op, write_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src, hold, flush,
        input  cmd_ready, wr_sel, wd_sel, reg_write, busy, done, err_op, write_count
    );
endinterface

// File: rtl/regwrite_sequencer.sv
// Write-back sequencer owning the register-file write port: issues single writes,
// the two-write POP (rt then $sp), stalls on hold and drops the command on flush.
module regwrite_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    regwrite_sequencer_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR1  = 2'd1;
    localparam logic [1:0] S_WR2  = 2'd2;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WR_RT   = 3'd1;
    localparam logic [2:0] OP_WR_RD   = 3'd2;
    localparam logic [2:0] OP_WR_RA   = 3'd3;
    localparam logic [2:0] OP_WR_SP   = 3'd4;
    localparam logic [2:0] OP_POP     = 3'd5;
    localparam logic [2:0] OP_LINK_RD = 3'd6;
    localparam logic [2:0] OP_RSVD    = 3'd7;

    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_SP = 2'b01;
    localparam logic [1:0] SEL_RA = 2'b10;
    localparam logic [1:0] SEL_RD = 2'b11;

    localparam logic [2:0] SRC_ALU = 3'd0;
    localparam logic [2:0] SRC_MDR = 3'd1;
    localparam logic [2:0] SRC_PC  = 3'd6;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [2:0]         src_q, src_d;
    logic               err_op_q, err_op_d;
    logic [COUNT_W-1:0] write_count_q, write_count_d;

    logic               cmd_ready_s;
    logic               accept_s;
    logic               write_s;
    logic               final_s;
    logic [1:0]         wr_sel_s;
    logic [2:0]         wd_sel_s;

    // Handshake and write strobe; reset also gates the write so an interrupted command never lands.
    always_comb begin
        cmd_ready_s = (state_q == S_IDLE) & ~bus.hold & ~bus.flush & ~reset;
        accept_s    = bus.cmd_valid & cmd_ready_s;
        write_s     = (state_q != S_IDLE) & ~bus.hold & ~bus.flush & ~reset;
    end

    // Next-state, command latch and retired-write counter.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        src_d         = src_q;
        err_op_d      = 1'b0;
        write_count_d = write_count_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d     = bus.cmd_op;
                    src_d    = bus.cmd_src;
                    err_op_d = (bus.cmd_op == OP_RSVD);
                    if ((bus.cmd_op == OP_NOP) || (bus.cmd_op == OP_RSVD)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WR1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR1: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (!bus.hold) begin
                    state_d = (op_q == OP_POP) ? S_WR2 : S_IDLE;
                end else begin
                    state_d = S_WR1;
                end
            end
            S_WR2: begin
                if (bus.flush || !bus.hold) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR2;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (write_s) begin
            write_count_d = write_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            write_count_d = write_count_q;
        end
    end

    // Write-port select decode from registered state only (no path from cmd_* or hold/flush).
    always_comb begin
        wr_sel_s = SEL_RT;
        wd_sel_s = SRC_ALU;
        final_s  = 1'b0;
        case (state_q)
            S_WR1: begin
                final_s = (op_q != OP_POP);
                case (op_q)
                    OP_WR_RT:   begin wr_sel_s = SEL_RT; wd_sel_s = src_q;   end
                    OP_WR_RD:   begin wr_sel_s = SEL_RD; wd_sel_s = src_q;   end
                    OP_WR_RA:   begin wr_sel_s = SEL_RA; wd_sel_s = SRC_PC;  end
                    OP_WR_SP:   begin wr_sel_s = SEL_SP; wd_sel_s = SRC_ALU; end
                    OP_POP:     begin wr_sel_s = SEL_RT; wd_sel_s = SRC_MDR; end
                    OP_LINK_RD: begin wr_sel_s = SEL_RD; wd_sel_s = SRC_PC;  end
                    default:    begin wr_sel_s = SEL_RT; wd_sel_s = SRC_ALU; end
                endcase
            end
            S_WR2: begin
                wr_sel_s = SEL_SP;
                wd_sel_s = SRC_ALU;
                final_s  = 1'b1;
            end
            default: begin
                wr_sel_s = SEL_RT;
                wd_sel_s = SRC_ALU;
                final_s  = 1'b0;
            end
        endcase
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            src_q         <= 3'd0;
            err_op_q      <= 1'b0;
            write_count_q <= {COUNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            src_q         <= src_d;
            err_op_q      <= err_op_d;
            write_count_q <= write_count_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_s;
    assign bus.wr_sel      = wr_sel_s;
    assign bus.wd_sel      = wd_sel_s;
    assign bus.reg_write   = write_s;
    assign bus.done        = write_s & final_s;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err_op      = err_op_q;
    assign bus.write_count = write_count_q;
endmodule
